// File: rtl/ss_sequencer.sv
// Save-state sequencer: walks slave indices, queries each slave's size/width, and either
// streams its contents out (save) or writes a received stream back into it (load).
module ss_sequencer #(
   parameter int NUM_SLAVES = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_save,
   input  logic        start_load,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  ss_idx,
   output logic        ss_query,
   output logic        ss_read,
   output logic        ss_write,
   output logic [23:0] ss_addr,
   output logic [63:0] ss_wdata,
   input  logic        ss_ack,
   input  logic [63:0] ss_rdata,
   input  logic [31:0] ss_size,
   input  logic [1:0]  ss_width,
   output logic        out_valid,
   output logic [63:0] out_data,
   input  logic        out_ready,
   input  logic        in_valid,
   input  logic [63:0] in_data,
   output logic        in_ready
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_QUERY  = 3'd1;
   localparam logic [2:0] S_HEADER = 3'd2;
   localparam logic [2:0] S_XREQ   = 3'd3;
   localparam logic [2:0] S_XSTR   = 3'd4;
   localparam logic [2:0] S_NEXT   = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;
   localparam logic [2:0] S_FAIL   = 3'd7;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] LAST_IDX = 8'(NUM_SLAVES - 1);

   logic [2:0]  state_q, state_d;
   logic        load_q, load_d;
   logic        error_q, error_d;
   logic [7:0]  idx_q, idx_d;
   logic [23:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] odata_q, odata_d;
   logic [31:0] size_q, size_d;
   logic [1:0]  width_q, width_d;
   logic [7:0]  tmo_q, tmo_d;

   logic tmo_hit, last_word, hdr_ok;

   // Strobes and stream handshakes decode straight from state so reset drops them at once.
   assign ss_query  = (state_q == S_QUERY);
   assign ss_read   = (state_q == S_XREQ) && !load_q;
   assign ss_write  = (state_q == S_XREQ) && load_q;
   assign out_valid = !load_q && ((state_q == S_HEADER) || (state_q == S_XSTR));
   assign in_ready  = load_q && ((state_q == S_HEADER) || (state_q == S_XSTR));
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_FINISH) || (state_q == S_FAIL);
   assign error     = error_q;
   assign ss_idx    = idx_q;
   assign ss_addr   = addr_q;
   assign ss_wdata  = wdata_q;
   assign out_data  = odata_q;

   assign tmo_hit   = !ss_ack && (tmo_q == TMO_LAST);
   assign last_word = ({8'd0, addr_q} == (size_q - 32'd1));
   assign hdr_ok    = (in_data[63:56] == idx_q) && (in_data[49:48] == width_q) &&
                      (in_data[31:0] == size_q);

   always_comb begin
      state_d = state_q;
      load_d  = load_q;
      error_d = error_q;
      idx_d   = idx_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      odata_d = odata_q;
      size_d  = size_q;
      width_d = width_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (start_save || start_load) begin
               state_d = S_QUERY;
               load_d  = !start_save;
               error_d = 1'b0;
               idx_d   = 8'd0;
               tmo_d   = 8'd0;
            end
         end
         S_QUERY: begin
            if (ss_ack) begin
               size_d  = ss_size;
               width_d = ss_width;
               odata_d = {idx_q, 6'd0, ss_width, 16'd0, ss_size};
               state_d = (ss_size == 32'd0) ? S_NEXT : S_HEADER;
            end else if (tmo_hit) begin
               state_d = S_NEXT;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_HEADER: begin
            addr_d = 24'd0;
            tmo_d  = 8'd0;
            if (load_q) begin
               if (in_valid) begin
                  state_d = hdr_ok ? S_XSTR : S_FAIL;
                  error_d = !hdr_ok;
               end
            end else if (out_ready) begin
               state_d = S_XREQ;
            end
         end
         S_XREQ: begin
            if (ss_ack) begin
               if (!load_q) begin
                  odata_d = ss_rdata;
                  state_d = S_XSTR;
               end else if (last_word) begin
                  state_d = S_NEXT;
               end else begin
                  addr_d  = addr_q + 24'd1;
                  state_d = S_XSTR;
               end
            end else if (tmo_hit) begin
               state_d = S_FAIL;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_XSTR: begin
            // Load fetches the next word before writing it; save drains the word just read.
            if (load_q) begin
               if (in_valid) begin
                  wdata_d = in_data;
                  tmo_d   = 8'd0;
                  state_d = S_XREQ;
               end
            end else if (out_ready) begin
               if (last_word) begin
                  state_d = S_NEXT;
               end else begin
                  addr_d  = addr_q + 24'd1;
                  tmo_d   = 8'd0;
                  state_d = S_XREQ;
               end
            end
         end
         S_NEXT: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_FINISH;
            end else begin
               idx_d   = idx_q + 8'd1;
               tmo_d   = 8'd0;
               state_d = S_QUERY;
            end
         end
         S_FINISH: state_d = S_IDLE;
         S_FAIL:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         error_q <= 1'b0;
         idx_q   <= 8'd0;
         addr_q  <= 24'd0;
         wdata_q <= 64'd0;
         odata_q <= 64'd0;
         size_q  <= 32'd0;
         width_q <= 2'd0;
         tmo_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         load_q  <= load_d;
         error_q <= error_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         odata_q <= odata_d;
         size_q  <= size_d;
         width_q <= width_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_ss_sequencer.sv
// Bench for ss_sequencer: slave and stream models around the DUT, scoreboarded output words
// and slave writes.
module tb_ss_sequencer;

   logic        clock, reset, start_save, start_load;
   logic        busy, done, error;
   logic [7:0]  ss_idx;
   logic        ss_query, ss_read, ss_write;
   logic [23:0] ss_addr;
   logic [63:0] ss_wdata;
   logic        ss_ack;
   logic [63:0] ss_rdata;
   logic [31:0] ss_size;
   logic [1:0]  ss_width;
   logic        out_valid, out_ready, in_valid, in_ready;
   logic [63:0] out_data, in_data;

   ss_sequencer #(.NUM_SLAVES(2), .TIMEOUT(255)) dut (
      .clock(clock), .reset(reset), .start_save(start_save), .start_load(start_load),
      .busy(busy), .done(done), .error(error),
      .ss_idx(ss_idx), .ss_query(ss_query), .ss_read(ss_read), .ss_write(ss_write),
      .ss_addr(ss_addr), .ss_wdata(ss_wdata),
      .ss_ack(ss_ack), .ss_rdata(ss_rdata), .ss_size(ss_size), .ss_width(ss_width),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
   );

   localparam logic [63:0] HDR = 64'h0001_0000_0000_0003;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] exp_q[$];
   logic [87:0] exp_w[$];
   logic [63:0] in_src[$];
   logic [63:0] sl_mem[4];
   logic [31:0] sl_size;
   logic [1:0]  sl_width;
   logic [63:0] held_val;
   bit rw_ack_en, feed_en, bp_en, in_take, held, err_at_done, got;
   int bp_cnt, done_cnt, wr_cnt, rd_cycles, extra_cnt, chg_cnt, multi_cnt, cyc;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Slave, output-ready and load-stream models update just after each rising edge.
   initial begin
      bp_cnt = 0;
      forever begin
         @(posedge clock);
         #1;
         ss_ack = 1'b0; ss_size = 32'd0; ss_width = 2'd0; ss_rdata = 64'd0;
         if (ss_query && ss_idx == 8'd0) begin
            ss_ack = 1'b1; ss_size = sl_size; ss_width = sl_width;
         end else if ((ss_read || ss_write) && rw_ack_en) begin
            ss_ack = 1'b1;
            ss_rdata = (ss_addr < 24'd4) ? sl_mem[ss_addr[1:0]] : 64'd0;
         end
         if (bp_en) begin
            if (out_ready) begin
               out_ready = 1'b0; bp_cnt = 0;
            end else if (out_valid) begin
               bp_cnt++;
               if (bp_cnt >= 1000) out_ready = 1'b1;
            end
         end else begin
            out_ready = 1'b1;
         end
         if (in_take && in_src.size() > 0) void'(in_src.pop_front());
         in_valid = feed_en && (in_src.size() > 0);
         in_data  = in_valid ? in_src[0] : 64'd0;
      end
   end

   // Monitor on the falling edge, where every signal is settled before the next capture.
   initial begin
      held = 1'b0;
      forever begin
         @(negedge clock);
         in_take = in_valid && in_ready;
         if (out_valid) begin
            if (!held) begin
               held = 1'b1; held_val = out_data;
            end else if (out_data !== held_val) begin
               chg_cnt++;
            end
            if (out_ready) begin
               if (exp_q.size() == 0) extra_cnt++;
               else check("out_word", out_data, exp_q.pop_front());
               held = 1'b0;
            end
         end else begin
            held = 1'b0;
         end
         if (ss_write && ss_ack) begin
            wr_cnt++;
            if (exp_w.size() == 0) extra_cnt++;
            else check("ss_write", {ss_addr, ss_wdata}, exp_w.pop_front());
         end
         if (ss_read) rd_cycles++;
         if ((int'(ss_query) + int'(ss_read) + int'(ss_write)) > 1) multi_cnt++;
         if (done) begin
            done_cnt++; err_at_done = error;
         end
      end
   end

   task automatic clr();
      done_cnt = 0; wr_cnt = 0; rd_cycles = 0; extra_cnt = 0; chg_cnt = 0;
      exp_q.delete(); exp_w.delete(); in_src.delete();
   endtask

   task automatic push_save();
      exp_q.push_back(HDR); exp_q.push_back(64'h11);
      exp_q.push_back(64'h22); exp_q.push_back(64'h33);
   endtask

   task automatic start(input bit sv, input bit ld);
      @(negedge clock);
      start_save = sv; start_load = ld;
      @(negedge clock);
      start_save = 1'b0; start_load = 1'b0;
   endtask

   task automatic wait_done(input int max, output bit ok, output int n);
      ok = 1'b0; n = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clock);
         n++;
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clock);
   endtask

   initial begin
      reset = 1'b1; start_save = 1'b0; start_load = 1'b0;
      ss_ack = 1'b0; ss_rdata = 64'd0; ss_size = 32'd0; ss_width = 2'd0;
      out_ready = 1'b0; in_valid = 1'b0; in_data = 64'd0;
      rw_ack_en = 1'b1; feed_en = 1'b0; bp_en = 1'b0; in_take = 1'b0;
      err_at_done = 1'b0; multi_cnt = 0;
      sl_size = 32'd3; sl_width = 2'd1;
      sl_mem[0] = 64'h11; sl_mem[1] = 64'h22; sl_mem[2] = 64'h33; sl_mem[3] = 64'h44;
      clr();
      repeat (3) @(negedge clock);
      check("rst_ctrl", {busy, done, error, ss_query, ss_read, ss_write, out_valid, in_ready}, 0);
      check("rst_idx_addr", {ss_idx, ss_addr}, 0);
      check("rst_data", {out_data, ss_wdata}, 0);
      reset = 1'b0;

      // Save with slave1 absent (query times out and is skipped)
      clr(); push_save();
      start(1'b1, 1'b0);
      check("save_busy", busy, 1);
      wait_done(2000, got, cyc);
      check("save_done", got, 1);
      check("save_err", err_at_done, 0);
      check("save_done_cnt", done_cnt, 1);
      check("save_left", exp_q.size(), 0);
      check("save_extra", extra_cnt, 0);
      check("save_idle", busy, 0);

      // Load the same stream back
      clr();
      in_src.push_back(HDR); in_src.push_back(64'h11);
      in_src.push_back(64'h22); in_src.push_back(64'h33);
      exp_w.push_back({24'd0, 64'h11}); exp_w.push_back({24'd1, 64'h22});
      exp_w.push_back({24'd2, 64'h33});
      feed_en = 1'b1;
      start(1'b0, 1'b1);
      wait_done(2000, got, cyc);
      check("load_done", got, 1);
      check("load_err", err_at_done, 0);
      check("load_wr_cnt", wr_cnt, 3);
      check("load_wr_left", exp_w.size(), 0);
      check("load_extra", extra_cnt, 0);
      check("load_consumed", in_src.size(), 0);
      feed_en = 1'b0;

      // Load with a header claiming size 4
      clr();
      in_src.push_back(64'h0001_0000_0000_0004); in_src.push_back(64'h11);
      feed_en = 1'b1;
      start(1'b0, 1'b1);
      wait_done(2000, got, cyc);
      check("mm_done", got, 1);
      check("mm_err", err_at_done, 1);
      check("mm_wr_cnt", wr_cnt, 0);
      check("mm_sticky", error, 1);
      feed_en = 1'b0;
      in_src.delete();

      // Save under heavy back-pressure; also checks error clears on start
      clr(); push_save();
      bp_en = 1'b1;
      start(1'b1, 1'b0);
      check("bp_err_clr", error, 0);
      wait_done(20000, got, cyc);
      check("bp_done", got, 1);
      check("bp_err", err_at_done, 0);
      check("bp_left", exp_q.size(), 0);
      check("bp_extra", extra_cnt, 0);
      check("bp_stable", chg_cnt, 0);
      check("bp_long", cyc > 4000, 1);
      bp_en = 1'b0;

      // Both starts together -> save; a start while busy is ignored
      clr(); push_save();
      start(1'b1, 1'b1);
      repeat (5) @(negedge clock);
      start_save = 1'b1; start_load = 1'b1;
      @(negedge clock);
      start_save = 1'b0; start_load = 1'b0;
      wait_done(2000, got, cyc);
      check("both_done", got, 1);
      check("both_err", err_at_done, 0);
      check("both_wr_cnt", wr_cnt, 0);
      check("both_left", exp_q.size(), 0);
      repeat (10) @(negedge clock);
      check("both_no_restart", {busy, done_cnt[7:0]}, {1'b0, 8'd1});
      check("both_extra", extra_cnt, 0);

      // Reset during the second read, then a full restart
      clr(); push_save();
      start(1'b1, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clock);
         if (ss_read && ss_addr == 24'd1) begin
            got = 1'b1;
            break;
         end
      end
      check("abort_reached", got, 1);
      #2 reset = 1'b1;
      #1;
      check("abort_strobes", {ss_query, ss_read, ss_write, out_valid, in_ready}, 0);
      check("abort_busy", busy, 0);
      @(negedge clock);
      check("abort_idx_addr", {ss_idx, ss_addr}, 0);
      check("abort_popped", exp_q.size(), 2);
      reset = 1'b0;
      clr(); push_save();
      start(1'b1, 1'b0);
      wait_done(2000, got, cyc);
      check("restart_done", got, 1);
      check("restart_err", err_at_done, 0);
      check("restart_left", exp_q.size(), 0);
      check("restart_extra", extra_cnt, 0);

      // Slave withholds ss_ack on reads
      clr();
      exp_q.push_back(HDR);
      rw_ack_en = 1'b0;
      start(1'b1, 1'b0);
      wait_done(2000, got, cyc);
      check("tmo_done", got, 1);
      check("tmo_err", err_at_done, 1);
      check("tmo_read_cycles", rd_cycles, 255);
      check("tmo_left", exp_q.size(), 0);
      check("tmo_extra", extra_cnt, 0);
      rw_ack_en = 1'b1;

      check("strobe_onehot", multi_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/ss_sequencer.md
SS_SEQUENCER -- requirements
Module: ss_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 16: number of save-state slave indices walked, 0..NUM_SLAVES-1.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles to wait for ss_ack before the timeout rule applies.
REQ-003 SHALL have port clock, input, 1: single clock for all logic.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have ports start_save and start_load, inputs, 1 each: one-cycle start requests.
REQ-006 SHALL have outputs busy (1), done (1, one-cycle pulse) and error (1, sticky until the next start).
REQ-007 SHALL have outputs ss_idx (8), ss_query (1), ss_read (1), ss_write (1), ss_addr (24) and ss_wdata (64): the slave-bus request side.
REQ-008 SHALL have inputs ss_ack (1), ss_rdata (64), ss_size (32) and ss_width (2): the slave response; ss_width is 0=8-bit, 1=16-bit.
REQ-009 SHALL have outputs out_valid (1) and out_data (64), and input out_ready (1): the save stream.
REQ-010 SHALL have inputs in_valid (1) and in_data (64), and output in_ready (1): the load stream.

Function
REQ-011 SHALL implement states IDLE, QUERY, HEADER, XFER_REQ, XFER_STREAM, NEXT, FINISH, FAIL.
REQ-012 In IDLE with busy=0, start_save or start_load SHALL enter QUERY with ss_idx=0, clear error and set busy next cycle; if both are asserted, save wins.
REQ-013 Start requests received while busy=1 SHALL be ignored.
REQ-014 QUERY SHALL hold ss_query=1 until ss_ack, then latch ss_size and ss_width in the same cycle.
REQ-015 Query completion SHALL branch on the result:
- latched size 0, or no ack within TIMEOUT cycles: skip the slave and go to NEXT;
- otherwise go to HEADER.
REQ-016 The header word SHALL be {ss_idx[7:0], 6'd0, width[1:0], 16'd0, size[31:0]}.
REQ-017 HEADER in save SHALL drive the header on out_data with out_valid=1, held stable until out_ready=1.
REQ-018 HEADER in load SHALL assert in_ready and accept one word on in_valid; a mismatch of idx, width or size against the query result SHALL go to FAIL.
REQ-019 XFER_REQ SHALL step a word counter ss_addr from 0 to size-1, starting at 0 for each slave.
REQ-020 XFER_REQ in save SHALL hold ss_read=1 until ss_ack, then capture ss_rdata into out_data.
REQ-021 XFER_REQ in load SHALL hold ss_write=1 with ss_wdata set to the word last accepted from the load stream, until ss_ack.
REQ-022 Any ss_ack timeout in XFER_REQ SHALL go to FAIL.
REQ-023 In save, XFER_STREAM SHALL hold out_valid=1 with stable out_data until out_ready; the transfer then completes and ss_addr increments.
REQ-024 In load, XFER_STREAM SHALL precede XFER_REQ: assert in_ready and accept a word when in_valid=1.
REQ-025 After the word at ss_addr=size-1, the sequencer SHALL go to NEXT with no extra word.
REQ-026 At most one of ss_query, ss_read and ss_write SHALL be high in any cycle.
REQ-027 Each strobe SHALL deassert the cycle after its ss_ack; an ss_ack with no strobe high SHALL be ignored.
REQ-028 NEXT SHALL increment ss_idx and return to QUERY; when ss_idx=NUM_SLAVES-1 it SHALL go to FINISH instead.
REQ-029 FINISH SHALL pulse done for one cycle, clear busy and return to IDLE.
REQ-030 FAIL SHALL set error=1, pulse done, clear busy and return to IDLE.
REQ-031 The timeout counter SHALL be 8 bits wide and reset on each new strobe assertion.
REQ-032 Stream back-pressure of any length SHALL NOT cause a timeout or a FAIL.

Reset
REQ-033 While reset is asserted, in every cycle: state=IDLE; busy, done, error, ss_query, ss_read, ss_write, out_valid and in_ready =0; ss_idx, ss_addr, ss_wdata, out_data and the counters =0.
REQ-034 Reset asserted mid-transfer SHALL abort immediately with no further strobes or stream handshakes; the first start after reset release SHALL begin at ss_idx=0.

Verification
REQ-035 Save scenario: NUM_SLAVES=2; slave0 size=3, width=1, data 0x11,0x22,0x33; slave1 absent; out_ready=1. Required response:
- out stream: header 0x0001_0000_0000_0003, then 0x11, 0x22, 0x33;
- done pulse, error=0.
REQ-036 Load scenario: the same stream fed to in_data. Required response:
- three ss_write cycles at ss_addr 0,1,2 with ss_wdata 0x11, 0x22, 0x33;
- done, error=0.
REQ-037 Load header mismatch: header size=4 against slave size=3. Required response:
- FAIL;
- error=1, done pulse;
- zero ss_write.
REQ-038 Back-pressure: out_ready low for 1000 cycles per word. Required response:
- out_data stable while held;
- no error;
- identical output words.
REQ-039 Abort and timeout scenarios:
- reset during the second ss_read: all strobes drop asynchronously, busy=0; a restart yields the full correct stream;
- slave ss_ack withheld on ss_read: error=1 after 255 cycles.
REQ-040 start_load asserted together with start_save SHALL perform a save; start_save pulsed while busy SHALL be ignored.
